// File: rtl/intra_blk_collector.sv
// intra_blk_collector: gathers 4x4 sub-block beats of one intra TU, tracks
// reconstructed-unit availability and the data-beat count, and raises tu_done
// (with back-pressure on bStop) when the TU's end beat has been accepted.
// Optional macro INTRA_COL_CHECK_EN builds a sequence checker feeding seq_err.
module intra_blk_collector #(
  parameter bit isChroma = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  tuSize,
  input  logic [2:0]  X,
  input  logic [2:0]  Y,
  input  logic [2:0]  order,
  input  logic [3:0]  preStage,
  input  logic [1:0]  cIdx,
  input  logic        in_valid,
  input  logic        out_ready,
  output logic        bStop,
  output logic        tu_done,
  output logic [1:0]  tu_cIdx,
  output logic [6:0]  blk_cnt,
  output logic [63:0] avail_map,
  output logic        seq_err
);

  localparam int unsigned MAP_W   = 64;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned CNT_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               size_ok;
  logic               accept;
  logic               take;
  logic               is_data;
  logic               is_end;
  logic               first;
  logic [5:0]         bit_idx;
  logic [MAP_W-1:0]   map_base;
  logic [MAP_W-1:0]   map_d;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_d;
  logic               chk_err;

  // Beat classification and the next avail_map / blk_cnt values.
  always_comb begin
    size_ok  = (tuSize >= 3'd2) && (tuSize <= 3'd5);
    accept   = in_valid && !bStop;
    take     = accept && size_ok;
    is_data  = (preStage == 4'd8) || (tuSize == 3'd2);
    is_end   = (tuSize == 3'd2) ? (order != 3'd0) : (order == 3'd7);
    first    = take && (state_q == IDLE);
    bit_idx  = {Y, X};
    map_base = first ? '0 : avail_map;
    cnt_base = first ? '0 : blk_cnt;
    map_d    = map_base;
    cnt_d    = cnt_base;
    if (take && is_data) begin
      map_d[bit_idx] = 1'b1;
      if (cnt_base < CNT_W'(CNT_MAX)) begin
        cnt_d = cnt_base + CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = is_end ? DONE : RUN;
        end
      end
      RUN: begin
        if (take && is_end) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs; tu_cIdx is captured only on the TU's first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      bStop     <= 1'b0;
      tu_done   <= 1'b0;
      tu_cIdx   <= 2'd0;
      blk_cnt   <= '0;
      avail_map <= '0;
      seq_err   <= 1'b0;
    end else begin
      bStop     <= (state_d == DONE);
      tu_done   <= (state_d == DONE);
      blk_cnt   <= cnt_d;
      avail_map <= map_d;
      if (first) begin
        tu_cIdx <= isChroma ? cIdx : 2'd0;
      end
      seq_err   <= seq_err | (accept && !size_ok) | chk_err;
    end
  end

`ifdef INTRA_COL_CHECK_EN
  logic [2:0]       tu_size_q;
  logic [2:0]       exp_x_q;
  logic [2:0]       exp_y_q;
  logic [2:0]       exp_x_d;
  logic [2:0]       exp_y_d;
  logic [2:0]       n_m1;
  logic [2:0]       cur_x;
  logic [2:0]       cur_y;
  logic [CNT_W-1:0] exp_cnt;

  // Sequence checker: reverse-raster position, duplicates, final count, size change.
  always_comb begin
    case (tuSize)
      3'd3:    begin n_m1 = 3'd1; exp_cnt = CNT_W'(4);  end
      3'd4:    begin n_m1 = 3'd3; exp_cnt = CNT_W'(16); end
      3'd5:    begin n_m1 = 3'd7; exp_cnt = CNT_W'(64); end
      default: begin n_m1 = 3'd0; exp_cnt = CNT_W'(2);  end
    endcase
    cur_x   = first ? n_m1 : exp_x_q;
    cur_y   = first ? n_m1 : exp_y_q;
    exp_x_d = exp_x_q;
    exp_y_d = exp_y_q;
    chk_err = 1'b0;
    if (take) begin
      exp_x_d = cur_x;
      exp_y_d = cur_y;
      if (!first && (tuSize != tu_size_q)) begin
        chk_err = 1'b1;
      end
      if (is_data && (tuSize != 3'd2)) begin
        if ((X != cur_x) || (Y != cur_y)) begin
          chk_err = 1'b1;
        end
        if (map_base[bit_idx]) begin
          chk_err = 1'b1;
        end
        if (cur_x == 3'd0) begin
          exp_x_d = n_m1;
          exp_y_d = cur_y - 3'd1;
        end else begin
          exp_x_d = cur_x - 3'd1;
        end
      end
      if (is_end && (cnt_d != exp_cnt)) begin
        chk_err = 1'b1;
      end
    end
  end

  // Checker state: latched TU size and next expected position.
  always_ff @(posedge clk) begin
    if (rst) begin
      tu_size_q <= 3'd0;
      exp_x_q   <= 3'd0;
      exp_y_q   <= 3'd0;
    end else if (take) begin
      if (first) begin
        tu_size_q <= tuSize;
      end
      exp_x_q <= exp_x_d;
      exp_y_q <= exp_y_d;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_intra_blk_collector.sv
// Directed testbench for intra_blk_collector; a second instance with
// isChroma=1 runs in lockstep to cover the chroma cIdx latch.
module tb_intra_blk_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  tuSize;
  logic [2:0]  X;
  logic [2:0]  Y;
  logic [2:0]  order;
  logic [3:0]  preStage;
  logic [1:0]  cIdx;
  logic        in_valid;
  logic        out_ready;
  logic        bStop;
  logic        tu_done;
  logic [1:0]  tu_cIdx;
  logic [6:0]  blk_cnt;
  logic [63:0] avail_map;
  logic        seq_err;
  logic        c_bStop;
  logic        c_tu_done;
  logic [1:0]  c_tu_cIdx;
  logic [6:0]  c_blk_cnt;
  logic [63:0] c_avail_map;
  logic        c_seq_err;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_chk;

  always #5 clk = ~clk;

  intra_blk_collector #(.isChroma(1'b0)) dut (
    .clk(clk), .rst(rst), .tuSize(tuSize), .X(X), .Y(Y), .order(order),
    .preStage(preStage), .cIdx(cIdx), .in_valid(in_valid), .out_ready(out_ready),
    .bStop(bStop), .tu_done(tu_done), .tu_cIdx(tu_cIdx), .blk_cnt(blk_cnt),
    .avail_map(avail_map), .seq_err(seq_err)
  );

  intra_blk_collector #(.isChroma(1'b1)) dut_c (
    .clk(clk), .rst(rst), .tuSize(tuSize), .X(X), .Y(Y), .order(order),
    .preStage(preStage), .cIdx(cIdx), .in_valid(in_valid), .out_ready(out_ready),
    .bStop(c_bStop), .tu_done(c_tu_done), .tu_cIdx(c_tu_cIdx), .blk_cnt(c_blk_cnt),
    .avail_map(c_avail_map), .seq_err(c_seq_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one cycle.
  task automatic send(input logic [2:0] sz, input logic [2:0] x, input logic [2:0] y,
                      input logic [2:0] ord, input logic [3:0] pre, input logic [1:0] ci);
    tuSize = sz; X = x; Y = y; order = ord; preStage = pre; cIdx = ci;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Full reverse-raster data sequence for an NxN TU, order 7 on the last beat.
  task automatic send_tu(input logic [2:0] sz, input int n);
    for (int y = n - 1; y >= 0; y--) begin
      for (int x = n - 1; x >= 0; x--) begin
        send(sz, 3'(x), 3'(y), (x == 0 && y == 0) ? 3'd7 : 3'd0, 4'd8, 2'd0);
      end
    end
  endtask

  initial begin
`ifdef INTRA_COL_CHECK_EN
    exp_chk = 1'b1;
`else
    exp_chk = 1'b0;
`endif
    rst = 1'b1; tuSize = 3'd3; X = 3'd0; Y = 3'd0; order = 3'd0;
    preStage = 4'd8; cIdx = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    check("rst_tu_done", tu_done, 0);
    check("rst_bStop", bStop, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_avail_map", avail_map, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_tu_cIdx", tu_cIdx, 0);
    check("rst_c_tu_cIdx", c_tu_cIdx, 0);
    rst = 1'b0;
    step();

    // 8x8 TU, four data beats.
    send(3'd3, 3'd1, 3'd1, 3'd0, 4'd8, 2'd0);
    check("t8_first_cnt", blk_cnt, 1);
    check("t8_first_map", avail_map, 64'h200);
    check("t8_first_done", tu_done, 0);
    send(3'd3, 3'd0, 3'd1, 3'd0, 4'd8, 2'd0);
    send(3'd3, 3'd1, 3'd0, 3'd0, 4'd8, 2'd0);
    send(3'd3, 3'd0, 3'd0, 3'd7, 4'd8, 2'd0);
    check("t8_map", avail_map, 64'h303);
    check("t8_cnt", blk_cnt, 4);
    check("t8_done", tu_done, 1);
    check("t8_bStop", bStop, 1);
    check("t8_seq_err", seq_err, 0);
    step();
    check("t8_done_1cyc", tu_done, 0);
    check("t8_bStop_rel", bStop, 0);
    check("t8_map_hold", avail_map, 64'h303);

    // 16x16 TU with a prep beat first.
    send(3'd4, 3'd0, 3'd0, 3'd0, 4'd0, 2'd0);
    check("t16_prep_cnt", blk_cnt, 0);
    check("t16_prep_map", avail_map, 0);
    check("t16_prep_done", tu_done, 0);
    send_tu(3'd4, 4);
    check("t16_cnt", blk_cnt, 16);
    check("t16_map", avail_map, 64'h0F0F0F0F);
    check("t16_done", tu_done, 1);
    check("t16_seq_err", seq_err, 0);
    step();

    // 32x32 TU, 4 prep beats, held completion.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd5, 3'd0, 3'd0, 3'd0, 4'(i), 2'd0);
    send_tu(3'd5, 8);
    check("t32_map", avail_map, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t32_cnt", blk_cnt, 64);
    check("t32_done_c1", tu_done, 1);
    check("t32_bStop_c1", bStop, 1);
    send(3'd5, 3'd0, 3'd0, 3'd0, 4'd8, 2'd0);
    check("t32_done_c2", tu_done, 1);
    check("t32_ignore_cnt", blk_cnt, 64);
    step();
    check("t32_done_c3", tu_done, 1);
    check("t32_bStop_c3", bStop, 1);
    out_ready = 1'b1;
    step();
    check("t32_done_rel", tu_done, 0);
    check("t32_bStop_rel", bStop, 0);
    check("t32_map_hold", avail_map, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t32_seq_err", seq_err, 0);

    // Reset mid-TU abandons it.
    send(3'd4, 3'd3, 3'd3, 3'd0, 4'd8, 2'd0);
    send(3'd4, 3'd2, 3'd3, 3'd0, 4'd8, 2'd0);
    send(3'd4, 3'd1, 3'd3, 3'd0, 4'd8, 2'd0);
    send(3'd4, 3'd0, 3'd3, 3'd0, 4'd8, 2'd0);
    send(3'd4, 3'd3, 3'd2, 3'd0, 4'd8, 2'd0);
    check("abort_cnt5", blk_cnt, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_cnt", blk_cnt, 0);
    check("abort_map", avail_map, 0);
    check("abort_done", tu_done, 0);
    step();
    check("abort_done2", tu_done, 0);
    send_tu(3'd4, 4);
    check("abort_re_cnt", blk_cnt, 16);
    check("abort_re_map", avail_map, 64'h0F0F0F0F);
    check("abort_re_done", tu_done, 1);
    step();

    // 4x4 chroma TU: two beats, cIdx 2.
    send(3'd2, 3'd0, 3'd0, 3'd0, 4'd0, 2'd2);
    check("t4_first_cnt", blk_cnt, 1);
    check("t4_first_done", tu_done, 0);
    send(3'd2, 3'd0, 3'd0, 3'd2, 4'd0, 2'd2);
    check("t4_cnt", blk_cnt, 2);
    check("t4_map", avail_map, 64'h1);
    check("t4_done", tu_done, 1);
    check("t4_cidx_luma", tu_cIdx, 0);
    check("t4_cidx_chroma", c_tu_cIdx, 2);
    check("t4_seq_err", seq_err, 0);
    step();

    // Out-of-order 8x8 beats.
    send(3'd3, 3'd0, 3'd1, 3'd0, 4'd8, 2'd0);
    check("ooo_first_cnt", blk_cnt, 1);
    check("ooo_first_map", avail_map, 64'h100);
    check("ooo_seq_err1", seq_err, exp_chk);
    send(3'd3, 3'd1, 3'd1, 3'd0, 4'd8, 2'd0);
    check("ooo_seq_err2", seq_err, exp_chk);
    step();
    check("ooo_seq_err_sticky", seq_err, exp_chk);

    // Illegal tuSize is dropped and flagged.
    send(3'd6, 3'd0, 3'd0, 3'd7, 4'd8, 2'd0);
    check("bad_size_err", seq_err, 1);
    check("bad_size_cnt", blk_cnt, 2);
    check("bad_size_done", tu_done, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("bad_size_clr", seq_err, 0);

    // blk_cnt saturates at 64.
    for (int i = 0; i < 70; i++) send(3'd5, 3'd0, 3'd0, 3'd0, 4'd8, 2'd0);
    check("sat_cnt", blk_cnt, 64);
    check("sat_no_done", tu_done, 0);
    send(3'd5, 3'd0, 3'd0, 3'd7, 4'd8, 2'd0);
    check("sat_cnt_end", blk_cnt, 64);
    check("sat_done", tu_done, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
